clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 110 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// ICG enable controller: gates the clock after CFG_IDLE idle cycles, wakes through WAKE_CYC cycles before ACK.
// Outputs are registered from next state (one edge after sampled inputs); no backpressure, SE freezes all state.
module clk_gate_ctrl #(
   parameter int IDLE_W   = 4,
   parameter int WAKE_CYC = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ,
   input  logic              BUSY,
   input  logic              FORCE_ON,
   input  logic              SE,
   input  logic [IDLE_W-1:0] CFG_IDLE,
   output logic              E,
   output logic              TE,
   output logic              ACK,
   output logic              GATED,
   output logic [7:0]        GATE_CNT
);

   typedef enum logic [1:0] {ST_RUN, ST_COUNT, ST_GATED, ST_WAKE} state_t;

   localparam logic [3:0]        WAKE_LAST = 4'(WAKE_CYC - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;

   state_t            state;
   state_t            state_nxt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [IDLE_W-1:0] idle_nxt;
   logic [IDLE_W-1:0] idle_inc;
   logic [3:0]        wake_cnt;
   logic [3:0]        wake_nxt;
   logic              idle;

   assign TE       = SE;
   assign idle     = !REQ && !BUSY;
   assign idle_inc = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IDLE_W'(1);

   always_comb begin
      state_nxt = state;
      idle_nxt  = idle_cnt;
      wake_nxt  = wake_cnt;
      case (state)
         ST_RUN: begin
            if (FORCE_ON || !idle) begin
               idle_nxt = '0;
            end else if (CFG_IDLE == '0) begin
               state_nxt = ST_GATED;
               idle_nxt  = '0;
            end else begin
               state_nxt = ST_COUNT;
               idle_nxt  = IDLE_W'(1);
            end
         end
         ST_COUNT: begin
            // Activity is checked first so it wins over a threshold reached in the same cycle.
            if (FORCE_ON || !idle) begin
               state_nxt = ST_RUN;
               idle_nxt  = '0;
            end else if (idle_inc >= CFG_IDLE) begin
               state_nxt = ST_GATED;
               idle_nxt  = '0;
            end else begin
               idle_nxt = idle_inc;
            end
         end
         ST_GATED: begin
            if (FORCE_ON || !idle) begin
               state_nxt = ST_WAKE;
               wake_nxt  = '0;
            end
         end
         ST_WAKE: begin
            if (wake_cnt == WAKE_LAST) begin
               state_nxt = ST_RUN;
               wake_nxt  = '0;
            end else begin
               wake_nxt = wake_cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = ST_WAKE;
            wake_nxt  = '0;
         end
      endcase
   end

   // Reset parks in WAKE with E high so the gated domain is clocked through its own reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ST_WAKE;
         idle_cnt <= '0;
         wake_cnt <= '0;
         E        <= 1'b1;
         ACK      <= 1'b0;
         GATED    <= 1'b0;
         GATE_CNT <= '0;
      end else if (!SE) begin
         state    <= state_nxt;
         idle_cnt <= idle_nxt;
         wake_cnt <= wake_nxt;
         E        <= (state_nxt != ST_GATED);
         ACK      <= (state_nxt == ST_RUN) || (state_nxt == ST_COUNT);
         GATED    <= (state_nxt == ST_GATED);
         if ((state_nxt == ST_GATED) && (state != ST_GATED))
            GATE_CNT <= GATE_CNT + 8'd1;
      end
   end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: per-edge vector table through a scoreboard queue, plus reset and wrap sequences.
module tb_clk_gate_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       REQ;
   logic       BUSY;
   logic       FORCE_ON;
   logic       SE;
   logic [3:0] CFG_IDLE;
   logic       E;
   logic       TE;
   logic       ACK;
   logic       GATED;
   logic [7:0] GATE_CNT;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         id;
      logic       req;
      logic       busy;
      logic       force_on;
      logic       se;
      logic [3:0] cfg;
      logic       e;
      logic       ack;
      logic       gated;
      logic [7:0] gcnt;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   clk_gate_ctrl #(.IDLE_W(4), .WAKE_CYC(2)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .BUSY     (BUSY),
      .FORCE_ON (FORCE_ON),
      .SE       (SE),
      .CFG_IDLE (CFG_IDLE),
      .E        (E),
      .TE       (TE),
      .ACK      (ACK),
      .GATED    (GATED),
      .GATE_CNT (GATE_CNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic req, input logic busy, input logic force_on,
                               input logic se, input logic [3:0] cfg, input logic e,
                               input logic ack, input logic gated, input logic [7:0] gcnt);
      vec_t v;
      v.id = 0; v.req = req; v.busy = busy; v.force_on = force_on; v.se = se; v.cfg = cfg;
      v.e = e; v.ack = ack; v.gated = gated; v.gcnt = gcnt;
      return v;
   endfunction

   task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h want %0h", nm, id, act, exp);
      end
   endtask

   // Called just after a falling edge: drive, push expectation, compare after the next rising edge.
   task automatic step(input vec_t v);
      vec_t x;
      REQ = v.req; BUSY = v.busy; FORCE_ON = v.force_on; SE = v.se; CFG_IDLE = v.cfg;
      sb.push_back(v);
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", v.id, 8'd1, 8'd0);
      end else begin
         x = sb.pop_front();
         chk("E",        x.id, {7'd0, E},     {7'd0, x.e});
         chk("ACK",      x.id, {7'd0, ACK},   {7'd0, x.ack});
         chk("GATED",    x.id, {7'd0, GATED}, {7'd0, x.gated});
         chk("GATE_CNT", x.id, GATE_CNT,      x.gcnt);
         chk("TE",       x.id, {7'd0, TE},    {7'd0, x.se});
      end
      @(negedge CLK);
   endtask

   initial begin
      vec_t v;
      logic [7:0] gc_model;

      // req busy force se cfg | e ack gated gcnt
      tbl.push_back(mk(0,0,0,0,3, 1,0,0,0));   // WAKE wc=1
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,0));   // RUN, ACK after 2 edges
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,0));   // COUNT 1
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,0));   // COUNT 2
      tbl.push_back(mk(0,0,0,0,3, 0,0,1,1));   // gated on third idle edge
      tbl.push_back(mk(0,0,0,0,3, 0,0,1,1));
      tbl.push_back(mk(1,0,0,0,3, 1,0,0,1));   // one-cycle REQ pulse
      tbl.push_back(mk(0,0,0,0,3, 1,0,0,1));   // wake continues with REQ low
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,1));   // ACK three edges after launch
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,1));
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,1));
      tbl.push_back(mk(1,0,0,0,3, 1,1,0,1));   // activity on threshold cycle wins
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,1));
      tbl.push_back(mk(0,1,0,0,3, 1,1,0,1));   // BUSY counts as active
      tbl.push_back(mk(0,0,0,0,0, 0,0,1,2));   // CFG_IDLE=0 gates from RUN
      tbl.push_back(mk(0,0,1,0,0, 1,0,0,2));   // FORCE_ON goes through WAKE
      tbl.push_back(mk(0,0,1,0,0, 1,0,0,2));
      tbl.push_back(mk(0,0,1,0,0, 1,1,0,2));
      tbl.push_back(mk(0,0,1,0,0, 1,1,0,2));
      tbl.push_back(mk(0,0,1,0,0, 1,1,0,2));
      tbl.push_back(mk(0,0,0,0,0, 0,0,1,3));
      tbl.push_back(mk(0,1,0,0,0, 1,0,0,3));
      tbl.push_back(mk(0,0,0,0,3, 1,0,0,3));
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,3));
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,3));   // COUNT 1
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,3));   // COUNT 2
      for (int k = 0; k < 10; k++)            // scan freeze, inputs wiggling
         tbl.push_back(mk(logic'(k % 2), 0, logic'(k == 4), 1, 3, 1,1,0,3));
      tbl.push_back(mk(0,0,0,0,3, 0,0,1,4));   // resumes from 2, gates on next idle
      tbl.push_back(mk(1,0,0,0,3, 1,0,0,4));
      tbl.push_back(mk(0,0,0,0,3, 1,0,0,4));
      tbl.push_back(mk(0,0,0,0,3, 1,1,0,4));
      tbl.push_back(mk(0,0,0,0,5, 1,1,0,4));
      tbl.push_back(mk(0,0,0,0,5, 1,1,0,4));
      tbl.push_back(mk(0,0,0,0,1, 0,0,1,5));   // threshold lowered mid-count
      tbl.push_back(mk(1,0,0,1,3, 0,0,1,5));   // frozen in GATED
      tbl.push_back(mk(0,0,0,0,3, 0,0,1,5));

      RST = 1'b1; REQ = 1'b0; BUSY = 1'b0; FORCE_ON = 1'b0; SE = 1'b0; CFG_IDLE = 4'd3;
      #12;
      chk("rst_E",        0, {7'd0, E},     8'd1);
      chk("rst_ACK",      0, {7'd0, ACK},   8'd0);
      chk("rst_GATED",    0, {7'd0, GATED}, 8'd0);
      chk("rst_GATE_CNT", 0, GATE_CNT,      8'd0);
      SE = 1'b1;
      #1 chk("rst_TE_hi", 0, {7'd0, TE}, 8'd1);
      SE = 1'b0;
      #1 chk("rst_TE_lo", 0, {7'd0, TE}, 8'd0);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         v.id = i + 1;
         step(v);
      end

      gc_model = 8'd5;
      for (int n = 0; n < 252; n++) begin
         step(mk(1,0,0,0,3, 1,0,0,gc_model));
         step(mk(0,0,0,0,3, 1,0,0,gc_model));
         step(mk(0,0,0,0,3, 1,1,0,gc_model));
         gc_model = gc_model + 8'd1;
         step(mk(0,0,0,0,0, 0,0,1,gc_model));
         if (n == 250) chk("wrap_GATE_CNT", n, GATE_CNT, 8'd0);
      end

      step(mk(1,0,0,0,3, 1,0,0,8'd1));         // into WAKE, then reset mid-wake
      #2 RST = 1'b1;
      #1;
      chk("mid_rst_E",        0, {7'd0, E},     8'd1);
      chk("mid_rst_ACK",      0, {7'd0, ACK},   8'd0);
      chk("mid_rst_GATED",    0, {7'd0, GATED}, 8'd0);
      chk("mid_rst_GATE_CNT", 0, GATE_CNT,      8'd0);
      SE = 1'b1;
      #1 chk("mid_rst_TE", 0, {7'd0, TE}, 8'd1);
      SE = 1'b0; REQ = 1'b0;
      @(posedge CLK);
      #1;
      chk("held_rst_ACK", 0, {7'd0, ACK}, 8'd0);
      chk("held_rst_E",   0, {7'd0, E},   8'd1);
      @(negedge CLK);
      RST = 1'b0;
      step(mk(0,0,0,0,3, 1,0,0,0));
      step(mk(0,0,0,0,3, 1,1,0,0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
